// File: rtl/ci_command_sequencer.sv
// UART command engine for the CI harness: parses opcode/argument bytes and drives
// SoC clock enable, timed reset pulse, serial path selects and bounded clock-step runs.
module ci_command_sequencer #(
   parameter logic [7:0]  DEFAULT_RESET_LEN = 8'd50,
   parameter logic        RESET_CLK_EN      = 1'b1,
   parameter int unsigned ARG_TIMEOUT       = 27000000,
   parameter logic [7:0]  ACK_BYTE          = 8'hAA,
   parameter logic [7:0]  NAK_BYTE          = 8'hEE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   output logic       tx_en,
   output logic [7:0] tx_data,
   output logic       soc_clk_en,
   output logic       soc_reset,
   output logic       tx_sel,
   output logic       rx_gate,
   output logic       busy
);

   localparam int unsigned TW = $clog2(ARG_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(ARG_TIMEOUT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARG  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [7:0]    opcode;
   logic [1:0]    arg_left;
   logic [7:0]    arg_lo;
   logic [TW-1:0] to_cnt;
   logic [7:0]    resp_byte;
   logic [7:0]    reset_len;
   logic [7:0]    rst_cnt;
   logic [15:0]   step_cnt;
   logic          step_active;
   logic          drop_flag;

   logic          do_exec;
   logic [7:0]    exec_op;
   logic [15:0]   step_val;
   logic [7:0]    status;

   assign busy   = (state != S_IDLE);
   assign status = {soc_clk_en, soc_reset, tx_sel, rx_gate, step_active, drop_flag, 2'b00};

   // A command executes either straight from IDLE (no arguments) or on its last argument byte.
   always_comb begin
      do_exec  = 1'b0;
      exec_op  = opcode;
      step_val = {rx_data, arg_lo};
      case (state)
         S_IDLE: begin
            if (rx_valid && (rx_data <= 8'h07 || rx_data == 8'h0A)) begin
               do_exec = 1'b1;
               exec_op = rx_data;
            end
         end
         S_ARG: begin
            if (rx_valid && arg_left == 2'd1) do_exec = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         opcode      <= '0;
         arg_left    <= '0;
         arg_lo      <= '0;
         to_cnt      <= '0;
         resp_byte   <= '0;
         reset_len   <= DEFAULT_RESET_LEN;
         rst_cnt     <= '0;
         step_cnt    <= '0;
         step_active <= 1'b0;
         drop_flag   <= 1'b0;
         tx_en       <= 1'b0;
         tx_data     <= '0;
         soc_clk_en  <= RESET_CLK_EN;
         soc_reset   <= 1'b0;
         tx_sel      <= 1'b0;
         rx_gate     <= 1'b1;
      end else begin
         tx_en <= 1'b0;

         // Free-running pulse/step counters; a command executed this cycle overrides them below.
         if (rst_cnt != 8'd0) begin
            rst_cnt <= rst_cnt - 8'd1;
            if (rst_cnt == 8'd1) soc_reset <= 1'b0;
         end
         if (step_active) begin
            if (step_cnt != 16'd0) step_cnt <= step_cnt - 16'd1;
            if (step_cnt == 16'd1) begin
               soc_clk_en  <= 1'b0;
               step_active <= 1'b0;
            end
         end

         if (do_exec) begin
            case (exec_op)
               8'h00: begin
                  soc_clk_en  <= 1'b0;
                  step_active <= 1'b0;
                  step_cnt    <= '0;
               end
               8'h01: begin
                  soc_clk_en  <= 1'b1;
                  step_active <= 1'b0;
                  step_cnt    <= '0;
               end
               8'h02: begin
                  soc_reset <= 1'b1;
                  rst_cnt   <= (reset_len == 8'd0) ? 8'd1 : reset_len;
               end
               8'h03: begin
                  soc_reset <= 1'b0;
                  rst_cnt   <= '0;
               end
               8'h04: tx_sel    <= 1'b0;
               8'h05: tx_sel    <= 1'b1;
               8'h06: rx_gate   <= 1'b1;
               8'h07: rx_gate   <= 1'b0;
               8'h08: reset_len <= rx_data;
               8'h09: begin
                  step_cnt    <= step_val;
                  soc_clk_en  <= (step_val != 16'd0);
                  step_active <= (step_val != 16'd0);
               end
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  opcode <= rx_data;
                  to_cnt <= '0;
                  if (rx_data == 8'h08) begin
                     state    <= S_ARG;
                     arg_left <= 2'd1;
                  end else if (rx_data == 8'h09) begin
                     state    <= S_ARG;
                     arg_left <= 2'd2;
                  end else begin
                     state     <= S_RESP;
                     resp_byte <= !do_exec ? NAK_BYTE :
                                  (rx_data == 8'h0A) ? status : ACK_BYTE;
                  end
               end
            end
            S_ARG: begin
               if (rx_valid) begin
                  to_cnt <= '0;
                  if (arg_left == 2'd1) begin
                     state     <= S_RESP;
                     resp_byte <= ACK_BYTE;
                  end else begin
                     arg_lo   <= rx_data;
                     arg_left <= 2'd1;
                  end
               end else if (to_cnt == TO_LIMIT) begin
                  state     <= S_RESP;
                  resp_byte <= NAK_BYTE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_RESP: begin
               if (!tx_busy) begin
                  tx_en   <= 1'b1;
                  tx_data <= resp_byte;
                  state   <= S_IDLE;
                  if (opcode == 8'h0A) drop_flag <= 1'b0;
               end
               if (rx_valid) drop_flag <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ci_command_sequencer.sv
// Directed self-checking bench for ci_command_sequencer with a short argument timeout.
module tb_ci_command_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       soc_clk_en;
   logic       soc_reset;
   logic       tx_sel;
   logic       rx_gate;
   logic       busy;

   int n_total = 0;
   int n_bad   = 0;
   int rst_hi, clk_hi, tx_cnt, waited;
   logic [7:0] tx_last;

   ci_command_sequencer #(.ARG_TIMEOUT(100)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_busy    (tx_busy),
      .tx_en      (tx_en),
      .tx_data    (tx_data),
      .soc_clk_en (soc_clk_en),
      .soc_reset  (soc_reset),
      .tx_sel     (tx_sel),
      .rx_gate    (rx_gate),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle and sample outputs 1 ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (soc_reset)  rst_hi++;
      if (soc_clk_en) clk_hi++;
      if (tx_en) begin
         tx_cnt++;
         tx_last = tx_data;
      end
   endtask

   task automatic clr();
      rst_hi  = soc_reset  ? 1 : 0;
      clk_hi  = soc_clk_en ? 1 : 0;
      tx_cnt  = 0;
      tx_last = 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_tx(input string tag, input logic [7:0] exp);
      tx_cnt = 0;
      waited = 0;
      while (tx_cnt == 0 && waited < 300) begin
         tick();
         waited++;
      end
      check({tag, "_tx"}, tx_last, exp);
      tick();
      check({tag, "_txpulse"}, tx_en, 1'b0);
   endtask

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
      clr();
      ticks(3);
      check("rst_tx_en", tx_en, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_outs", {soc_clk_en, soc_reset, tx_sel, rx_gate, busy}, 5'b10010);
      reset = 1'b0;
      tick();

      // clock off, one ACK
      send(8'h00);
      check("clkoff", soc_clk_en, 1'b0);
      check("busy_resp", busy, 1'b1);
      wait_tx("clkoff", 8'hAA);

      // argument timeout leaves reset_len at its default
      send(8'h08);
      wait_tx("timeout", 8'hEE);
      check("timeout_window", (waited >= 100 && waited <= 104), 1'b1);
      check("timeout_idle", busy, 1'b0);
      clr();
      send(8'h02);
      ticks(60);
      check("pulse_default", rst_hi, 32'd50);
      check("pulse_default_ack", {tx_cnt[7:0], tx_last}, {8'd1, 8'hAA});

      // 0x03 cancels an active pulse
      send(8'h02);
      ticks(3);
      send(8'h03);
      check("rst_cancel", soc_reset, 1'b0);
      wait_tx("rst_cancel", 8'hAA);
      ticks(4);
      check("rst_cancel_hold", soc_reset, 1'b0);

      // reset_len = 5
      send(8'h08);
      send(8'h05);
      wait_tx("setlen", 8'hAA);
      clr();
      send(8'h02);
      ticks(12);
      check("pulse5", rst_hi, 32'd5);
      check("pulse5_ack", {tx_cnt[7:0], tx_last}, {8'd1, 8'hAA});

      // reset_len = 0 acts as 1
      send(8'h08);
      send(8'h00);
      wait_tx("setlen0", 8'hAA);
      clr();
      send(8'h02);
      ticks(6);
      check("pulse0", rst_hi, 32'd1);

      // 10-cycle step with status read mid-step
      clr();
      send(8'h09);
      send(8'h0A);
      send(8'h00);
      check("step_on", soc_clk_en, 1'b1);
      wait_tx("step_ack", 8'hAA);
      send(8'h0A);
      wait_tx("step_status", 8'h98);
      ticks(20);
      check("step_len", clk_hi, 32'd10);
      check("step_off", soc_clk_en, 1'b0);

      // dropped byte while response is held off
      send(8'h07);
      wait_tx("rxoff", 8'hAA);
      check("rxoff", rx_gate, 1'b0);
      tx_busy = 1'b1;
      send(8'h05);
      check("txsel", tx_sel, 1'b1);
      clr();
      ticks(3);
      send(8'h06);
      ticks(2);
      check("held_no_tx", tx_cnt, 32'd0);
      check("drop_rxgate", rx_gate, 1'b0);
      tx_busy = 1'b0;
      wait_tx("held_ack", 8'hAA);
      send(8'h0A);
      wait_tx("status_drop", 8'h24);
      send(8'h0A);
      wait_tx("status_clr", 8'h20);

      // unknown opcode
      send(8'hFF);
      wait_tx("unknown", 8'hEE);
      check("unknown_outs", {soc_clk_en, soc_reset, tx_sel, rx_gate}, 4'b0010);

      // reset during an active pulse
      send(8'h08);
      send(8'h05);
      wait_tx("setlen_b", 8'hAA);
      send(8'h02);
      tick();
      check("pulse_active", soc_reset, 1'b1);
      reset = 1'b1;
      tick();
      check("midrst_outs", {soc_clk_en, soc_reset, tx_sel, rx_gate, busy, tx_en}, 6'b100100);
      reset = 1'b0;
      ticks(2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
